// File: rtl/timer_pkg.sv
// Shared types and default constants for the TecTacToe turn timer.
package timer_pkg;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_HOLD, T_DONE} timer_state_t;

  localparam int SIM_CLK_FREQ_HZ    = 4;
  localparam int SYN_CLK_FREQ_HZ    = 25_000_000;
  localparam int DEFAULT_DURATION_S = 30;
  localparam int DEFAULT_SEC_W      = 6;
  localparam int DEFAULT_WARN_S     = 5;

endpackage

// File: rtl/turn_timer_tick_gen.sv
// Prescaler for the turn timer: counts enabled cycles and strobes on each wrap.
module tick_gen #(
  parameter int CLK_FREQ_HZ = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_FREQ_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // tick is high in the cycle whose rising edge wraps the prescaler.
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/turn_timer.sv
// Per-turn seconds countdown with pause, one-shot/auto-reload and low-time warning.
module turn_timer
  import timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = SYN_CLK_FREQ_HZ,
  parameter int DURATION_S  = DEFAULT_DURATION_S,
  parameter int SEC_W       = DEFAULT_SEC_W,
  parameter int WARN_S      = DEFAULT_WARN_S
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [SEC_W-1:0] secs_left,
  output logic             running,
  output logic             paused,
  output logic             warn,
  output logic             tick_1hz,
  output logic             expired,
  output logic [1:0]       state_dbg
);

  if (DURATION_S < 1 || DURATION_S >= 2**SEC_W) begin : g_bad_duration
    $error("turn_timer: DURATION_S out of range");
  end
  if (WARN_S < 0 || WARN_S >= 2**SEC_W) begin : g_bad_warn
    $error("turn_timer: WARN_S out of range");
  end
  if (CLK_FREQ_HZ < 2) begin : g_bad_freq
    $error("turn_timer: CLK_FREQ_HZ must be >= 2");
  end

  localparam logic [SEC_W-1:0] DUR_V  = SEC_W'(DURATION_S);
  localparam logic [SEC_W-1:0] WARN_V = SEC_W'(WARN_S);
  localparam logic [SEC_W-1:0] ONE_V  = SEC_W'(1);

  timer_state_t     state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic             warn_q, warn_d;
  logic             tick_q, tick_d;
  logic             exp_q, exp_d;
  logic             wrap;
  logic             pre_en;

  // The prescaler advances in every cycle the timer ends up running, including
  // the HOLD cycle in which pause is released, so a pause loses no time.
  assign pre_en = ((state_q == T_RUN) || (state_q == T_HOLD)) && !pause && !start;

  tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (start),
    .tick  (wrap)
  );

  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    tick_d  = 1'b0;
    exp_d   = 1'b0;
    if (start) begin
      secs_d  = DUR_V;
      state_d = pause ? T_HOLD : T_RUN;
    end else if ((state_q == T_RUN) || (state_q == T_HOLD)) begin
      if (pause) begin
        state_d = T_HOLD;
      end else begin
        state_d = T_RUN;
        if (wrap && (secs_q != '0)) begin
          tick_d = 1'b1;
          if (secs_q == ONE_V) begin
            exp_d = 1'b1;
            if (auto_reload) begin
              secs_d = DUR_V;
            end else begin
              secs_d  = '0;
              state_d = T_DONE;
            end
          end else begin
            secs_d = secs_q - ONE_V;
          end
        end
      end
    end
    warn_d = (secs_d != '0) && (secs_d <= WARN_V);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= T_IDLE;
      secs_q  <= '0;
      warn_q  <= 1'b0;
      tick_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      warn_q  <= warn_d;
      tick_q  <= tick_d;
      exp_q   <= exp_d;
    end
  end

  assign secs_left = secs_q;
  assign running   = (state_q == T_RUN);
  assign paused    = (state_q == T_HOLD);
  assign warn      = warn_q;
  assign tick_1hz  = tick_q;
  assign expired   = exp_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_turn_timer.sv
// Bench for turn_timer: directed scenarios plus random traffic against an elapsed-time model.
module tb_turn_timer;

  localparam int F     = 4;
  localparam int DUR   = 3;
  localparam int SEC_W = 4;
  localparam int WARN  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             auto_reload = 1'b0;
  logic [SEC_W-1:0] secs_left;
  logic             running, paused, warn, tick_1hz, expired;
  logic [1:0]       state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_cyc = -1;

  // Model: 0 idle, 1 run, 2 hold, 3 done; time tracked as counting cycles since load.
  int m_state = 0;
  int m_elapsed = 0;
  int m_secs = 0;
  bit m_tick = 0;
  bit m_exp = 0;

  turn_timer #(
    .CLK_FREQ_HZ (F),
    .DURATION_S  (DUR),
    .SEC_W       (SEC_W),
    .WARN_S      (WARN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .secs_left   (secs_left),
    .running     (running),
    .paused      (paused),
    .warn        (warn),
    .tick_1hz    (tick_1hz),
    .expired     (expired),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic model_update(input bit s, input bit p, input bit a, input bit r);
    m_tick = 0;
    m_exp  = 0;
    if (r) begin
      m_state = 0; m_elapsed = 0; m_secs = 0;
    end else if (s) begin
      m_elapsed = 0; m_secs = DUR; m_state = p ? 2 : 1;
    end else if (m_state == 1 || m_state == 2) begin
      if (p) begin
        m_state = 2;
      end else begin
        m_state = 1;
        m_elapsed++;
        if (m_elapsed % F == 0) begin
          m_tick = 1;
          m_secs = DUR - m_elapsed / F;
          if (m_secs == 0) begin
            m_exp = 1;
            if (a) begin
              m_elapsed = 0; m_secs = DUR;
            end else begin
              m_state = 3;
            end
          end
        end
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input bit want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0b exp=%0b", tag, cyc, got, want);
    end
  endtask

  task automatic check_all();
    bit exp_warn;
    exp_warn = (m_secs > 0) && (m_secs <= WARN);
    checks++;
    assert (secs_left === SEC_W'(m_secs)) else begin
      failures++;
      $error("FAIL secs_left cyc=%0d got=%0d exp=%0d", cyc, secs_left, m_secs);
    end
    checks++;
    assert (state_dbg === 2'(m_state)) else begin
      failures++;
      $error("FAIL state cyc=%0d got=%0d exp=%0d", cyc, state_dbg, m_state);
    end
    check_bit("running", running, m_state == 1);
    check_bit("paused", paused, m_state == 2);
    check_bit("warn", warn, exp_warn);
    check_bit("tick_1hz", tick_1hz, m_tick);
    check_bit("expired", expired, m_exp);
  endtask

  task automatic step(input bit s, input bit p, input bit a, input bit r);
    start = s; pause = p; auto_reload = a; reset = r;
    @(posedge clk);
    cyc++;
    model_update(s, p, a, r);
    if (s && !r) start_cyc = cyc;
    #1;
    check_all();
    if (expired === 1'b1) exp_cyc = cyc;
  endtask

  task automatic check_latency(input string tag, input int want);
    checks++;
    assert ((exp_cyc - start_cyc) === want) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, exp_cyc - start_cyc, want);
    end
  endtask

  initial begin
    bit p_lvl;
    // Reset held three cycles.
    repeat (3) step(0, 0, 0, 1);

    // One-shot countdown to DONE.
    exp_cyc = -1;
    step(1, 0, 0, 0);
    repeat (14) step(0, 0, 0, 0);
    check_latency("oneshot_latency", 12);

    // Pause for five cycles after two counting cycles.
    exp_cyc = -1;
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    repeat (15) step(0, 0, 0, 0);
    check_latency("pause_latency", 17);

    // Auto-reload: expiry every 12 cycles, zero never shown.
    exp_cyc = -1;
    step(1, 0, 1, 0);
    repeat (12) step(0, 0, 1, 0);
    check_latency("reload_first", 12);
    checks++;
    assert (secs_left === SEC_W'(DUR)) else begin
      failures++;
      $error("FAIL reload_secs got=%0d exp=%0d", secs_left, DUR);
    end
    repeat (12) step(0, 0, 1, 0);
    check_latency("reload_second", 24);
    check_bit("reload_running", running, 1'b1);

    // start coinciding with the final tick.
    step(1, 0, 0, 0);
    repeat (11) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check_bit("start_final_noexp", expired, 1'b0);
    checks++;
    assert (secs_left === SEC_W'(DUR)) else begin
      failures++;
      $error("FAIL start_final_secs got=%0d exp=%0d", secs_left, DUR);
    end
    repeat (3) step(0, 0, 0, 0);

    // Mid-count reset, then pause ignored in IDLE.
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    checks++;
    assert (secs_left === '0) else begin
      failures++;
      $error("FAIL midreset_secs got=%0d exp=0", secs_left);
    end
    repeat (4) step(0, 1, 0, 0);

    // Run to DONE, then pause ignored in DONE.
    step(1, 0, 0, 0);
    repeat (13) step(0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Random traffic.
    p_lvl = 0;
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) p_lvl = ~p_lvl;
      step($urandom_range(0, 19) == 0, p_lvl, 1'($urandom_range(0, 1)),
           $urandom_range(0, 149) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
